// File: rtl/top_cdt_trig_pkg.sv
// top_cdt_trig_pkg: shared state encoding and size constants for trig_sched.
package top_cdt_trig_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DEAD} state_e;
    localparam int DEF_N_SRC = 4;
    localparam int DEF_TMO_W = 16;
    localparam int CNT_W     = 32;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request after ptr_i (wrapping).
// Ports: req_i request vector, ptr_i last granted index, idx_o grant index, vld_o any request.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic [SW-1:0] idx_o,
    output logic          vld_o
);
    logic [SW-1:0] j;
    // Scan from farthest to nearest so the nearest request after ptr_i wins.
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        j     = '0;
        for (int k = N; k >= 1; k--) begin
            j = SW'((int'(ptr_i) + k) % N);
            if (req_i[j]) begin
                idx_o = j;
                vld_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/trig_sched.sv
// trig_sched: round-robin scheduler sharing one trigger output among N_SRC requesters.
// Ports: clk, rst_n (async active-low), in_live (flush when low), in_req/in_mask per source,
//        in_ack, user_dead, user_tmo, in_clr; out_trig/out_src grant pulse, out_busy, out_err,
//        out_cnt_acc/out_cnt_lost per-source 32-bit counters.
// Build option: TRIG_SCHED_CNT_EN enables the statistics counters (constant 0 otherwise).
module trig_sched
    import top_cdt_trig_pkg::*;
#(
    parameter int N_SRC = DEF_N_SRC,
    parameter int TMO_W = DEF_TMO_W,
    parameter int SW    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_live,
    input  logic [N_SRC-1:0]       in_req,
    input  logic [N_SRC-1:0]       in_mask,
    input  logic                   in_ack,
    input  logic [TMO_W-1:0]       user_dead,
    input  logic [TMO_W-1:0]       user_tmo,
    input  logic                   in_clr,
    output logic                   out_trig,
    output logic [SW-1:0]          out_src,
    output logic                   out_busy,
    output logic                   out_err,
    output logic [N_SRC*CNT_W-1:0] out_cnt_acc,
    output logic [N_SRC*CNT_W-1:0] out_cnt_lost
);
    state_e           state_q, state_d;
    logic [N_SRC-1:0] pend_q, pend_d, gnt_oh, set_v;
    logic [SW-1:0]    ptr_q, ptr_d, gnt_q, gnt_d, arb_idx;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             arb_vld;

    rr_arbiter #(.N(N_SRC), .SW(SW)) u_arb (
        .req_i(pend_q & in_mask),
        .ptr_i(ptr_q),
        .idx_o(arb_idx),
        .vld_o(arb_vld)
    );

    assign set_v    = in_req & in_mask & {N_SRC{in_live}};
    assign gnt_oh   = (state_q == ST_ISSUE) ? (N_SRC'(1) << gnt_q) : '0;
    // A request landing on its own grant cycle re-arms pending instead of being lost.
    assign pend_d   = in_live ? (((pend_q & ~gnt_oh) | set_v) & in_mask) : '0;
    assign out_trig = state_q == ST_ISSUE;
    assign out_src  = out_trig ? gnt_q : '0;
    assign out_busy = state_q != ST_IDLE;
    assign out_err  = state_q == ST_WAIT && !in_ack && user_tmo != '0 && cnt_q == user_tmo;

    // cnt_q counts WAIT_ACK cycles, then DEAD cycles, restarting at 0 on entry to each.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        if (!in_live) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (arb_vld) begin
                    state_d = ST_ISSUE;
                    gnt_d   = arb_idx;
                    ptr_d   = arb_idx;
                end
                ST_ISSUE: begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
                ST_WAIT: if (in_ack || out_err) begin
                    state_d = ST_DEAD;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + TMO_W'(1);
                ST_DEAD: if (cnt_q == user_dead) state_d = ST_IDLE;
                         else cnt_d = cnt_q + TMO_W'(1);
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            ptr_q   <= SW'(N_SRC - 1);
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef TRIG_SCHED_CNT_EN
    logic [CNT_W-1:0] acc_q  [N_SRC];
    logic [CNT_W-1:0] lost_q [N_SRC];
    logic [N_SRC-1:0] lost_v;

    assign lost_v = set_v & pend_q & ~gnt_oh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SRC; i++) begin
                acc_q[i]  <= '0;
                lost_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (in_clr) begin
                    acc_q[i]  <= '0;
                    lost_q[i] <= '0;
                end else begin
                    if (gnt_oh[i]) acc_q[i]  <= acc_q[i] + CNT_W'(1);
                    if (lost_v[i]) lost_q[i] <= lost_q[i] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < N_SRC; g++) begin : g_cnt
        assign out_cnt_acc[g*CNT_W +: CNT_W]  = acc_q[g];
        assign out_cnt_lost[g*CNT_W +: CNT_W] = lost_q[g];
    end
`else
    logic unused_clr;
    assign unused_clr   = in_clr;
    assign out_cnt_acc  = '0;
    assign out_cnt_lost = '0;
`endif
endmodule
